// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UDP TX AXI-Stream engine among NUM_SRC sources.
// Define UDP_TX_ARB_WDOG_EN to add the in-frame stall watchdog (ABORT/DRAIN states).
module udp_tx_arbiter #(
    parameter int  NUM_SRC     = 4,
    parameter int  DATA_W      = 8,
    parameter int  WDOG_CYCLES = 1024,
    localparam int IDW         = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic [IDW-1:0]            m_axis_tdest,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy
);

`ifdef UDP_TX_ARB_WDOG_EN
    typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;
    localparam int WW = $clog2(WDOG_CYCLES);
    logic [WW-1:0] wdog_q, wdog_d;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDW-1:0]     gidx_q, gidx_d;
    logic [IDW-1:0]     last_idx_q, last_idx_d;
    logic [IDW-1:0]     pick_idx, cand;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               req_found;
    logic               g_vld, g_last;
    logic [DATA_W-1:0]  g_data;

    assign g_vld  = s_axis_tvalid[gidx_q];
    assign g_last = s_axis_tlast[gidx_q];
    assign g_data = s_axis_tdata[gidx_q*DATA_W +: DATA_W];

    assign grant        = grant_q;
    assign m_axis_tdest = gidx_q;
    assign busy         = busy_q;

    // Rotating-priority scan: the source after the last owner has highest priority.
    always_comb begin
        req_found = 1'b0;
        pick_idx  = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDW'((int'(last_idx_q) + k) % NUM_SRC);
            if (!req_found && s_axis_tvalid[cand]) begin
                req_found = 1'b1;
                pick_idx  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        last_idx_d    = last_idx_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
`ifdef UDP_TX_ARB_WDOG_EN
        wdog_d        = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d           = XFER;
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            XFER: begin
                m_axis_tvalid         = g_vld;
                m_axis_tdata          = g_data;
                m_axis_tlast          = g_last;
                s_axis_tready[gidx_q] = m_axis_tready;
                if (g_vld && m_axis_tready) begin
                    if (g_last) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        last_idx_d = gidx_q;
                    end
`ifdef UDP_TX_ARB_WDOG_EN
                    wdog_d = '0;
                end else if (!g_vld) begin
                    // Only source-side starvation counts; engine back-pressure never does.
                    if (int'(wdog_q) == WDOG_CYCLES - 1) begin
                        state_d = ABORT;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
`endif
                end
            end
`ifdef UDP_TX_ARB_WDOG_EN
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                s_axis_tready[gidx_q] = 1'b1;
                if (g_vld && g_last) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    last_idx_d = gidx_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            gidx_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            last_idx_q <= IDW'(NUM_SRC - 1);
`ifdef UDP_TX_ARB_WDOG_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            last_idx_q <= last_idx_d;
`ifdef UDP_TX_ARB_WDOG_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

endmodule
